// File: rtl/button_press_classifier_if.sv
// Button-bank bus: tick strobe and raw buttons in, debounced levels and
// one-clock press-class event pulses out.
interface button_press_classifier_if #(
  parameter int N_CH = 4
);
  logic            tick;
  logic [N_CH-1:0] pb;
  logic [N_CH-1:0] pressed;
  logic [N_CH-1:0] is_long;
  logic [N_CH-1:0] short_pulse;
  logic [N_CH-1:0] long_pulse;
  logic [N_CH-1:0] repeat_pulse;

  // master: the button/tick source that consumes the events
  modport master (
    output tick, pb,
    input  pressed, is_long, short_pulse, long_pulse, repeat_pulse
  );

  // slave: the classifier itself
  modport slave (
    input  tick, pb,
    output pressed, is_long, short_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_press_classifier.sv
// Multi-channel push-button front end: sync, tick-based debounce and
// short / long / auto-repeat press classification per channel.
module bpc_chan #(
  parameter int DEB_TICKS    = 2,
  parameter int LONG_TICKS   = 10,
  parameter int REPEAT_TICKS = 3,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic pb_i,
  output logic pressed_o,
  output logic is_long_o,
  output logic short_o,
  output logic long_o,
  output logic repeat_o
);
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_LONG} state_e;

  localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEB_TICKS);
  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_TICKS);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             pressed_q, pressed_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  logic             pb_s;
  logic             rise, fall;
  logic [CNT_W-1:0] deb_inc, hold_inc, rep_inc;

  assign sync_d   = {sync_q[0], pb_i};
  assign pb_s     = sync_q[1];
  assign deb_inc  = deb_cnt_q + ONE_C;
  assign hold_inc = hold_cnt_q + ONE_C;
  assign rep_inc  = rep_cnt_q + ONE_C;

  // Debounce: a differing level must be seen on DEB_TICKS consecutive ticks.
  always_comb begin
    pressed_d = pressed_q;
    deb_cnt_d = deb_cnt_q;
    if (tick_i) begin
      if (pb_s != pressed_q) begin
        if (deb_inc == DEB_C) begin
          pressed_d = ~pressed_q;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end else begin
        deb_cnt_d = '0;
      end
    end
  end

  // Edges come from the next-state level so the FSM reacts on the same tick.
  assign rise = pressed_d & ~pressed_q;
  assign fall = ~pressed_d & pressed_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d    = S_PRESS;
          hold_cnt_d = '0;
        end
      end
      S_PRESS: begin
        // A release on the threshold tick wins: short only, never long.
        if (fall) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end else if (tick_i) begin
          if (hold_inc == LONG_C) begin
            state_d   = S_LONG;
            long_d    = 1'b1;
            rep_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
      end
      S_LONG: begin
        if (fall) begin
          state_d = S_IDLE;
        end else if (tick_i && (REPEAT_TICKS != 0)) begin
          if (rep_inc == REP_C) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      pressed_q  <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      pressed_q  <= pressed_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      short_q    <= short_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign pressed_o = pressed_q;
  assign is_long_o = (state_q == S_LONG);
  assign short_o   = short_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
endmodule

module button_press_classifier #(
  parameter int N_CH         = 4,
  parameter int DEB_TICKS    = 2,
  parameter int LONG_TICKS   = 10,
  parameter int REPEAT_TICKS = 3,
  parameter int CNT_W        = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  button_press_classifier_if.slave     bus
);
  logic [N_CH-1:0] pressed_w, is_long_w, short_w, long_w, repeat_w;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    bpc_chan #(
      .DEB_TICKS   (DEB_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (bus.tick),
      .pb_i     (bus.pb[c]),
      .pressed_o(pressed_w[c]),
      .is_long_o(is_long_w[c]),
      .short_o  (short_w[c]),
      .long_o   (long_w[c]),
      .repeat_o (repeat_w[c])
    );
  end

  assign bus.pressed      = pressed_w;
  assign bus.is_long      = is_long_w;
  assign bus.short_pulse  = short_w;
  assign bus.long_pulse   = long_w;
  assign bus.repeat_pulse = repeat_w;
endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench: expected events (dut, kind, channel, tick stamp) are queued
// at stimulus time and matched against every pulse the DUTs emit.
module tb_button_press_classifier;
  localparam int N = 4;
  localparam int K_SHORT = 0, K_LONG = 1, K_REP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_press_classifier_if #(.N_CH(N)) bus0();
  button_press_classifier_if #(.N_CH(N)) bus1();

  button_press_classifier #(.N_CH(N)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  button_press_classifier #(.N_CH(N), .REPEAT_TICKS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  int tn = 0;
  int cyc = 0;
  logic [1:0] ph = '0;
  logic mon_en = 1'b0;
  logic [31:0] sb[$];

  // dut0 ticks once every 4 clocks; dut1 ticks every clock
  initial bus0.tick = 1'b0;
  always @(negedge clk) begin
    ph       <= ph + 2'd1;
    bus0.tick <= (ph == 2'd3);
  end
  assign bus1.tick = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus0.tick) tn <= tn + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ev(input int d, input int k, input int ch, input int st);
    return {4'(d), 4'(k), 8'(ch), 16'(st)};
  endfunction

  function automatic logic [N-1:0] pick(input int d, input int k);
    logic [N-1:0] v;
    v = '0;
    case ({d[0], k[1:0]})
      3'b000: v = bus0.short_pulse;
      3'b001: v = bus0.long_pulse;
      3'b010: v = bus0.repeat_pulse;
      3'b100: v = bus1.short_pulse;
      3'b101: v = bus1.long_pulse;
      3'b110: v = bus1.repeat_pulse;
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 3; k++) begin
          logic [N-1:0] pv;
          pv = pick(d, k);
          for (int c = 0; c < N; c++)
            if (pv[c]) begin
              logic [31:0] obs;
              obs = ev(d, k, c, (d == 0) ? tn : cyc);
              if (sb.size() == 0) chk("sb_unexpected", obs, 32'hFFFF_FFFF);
              else chk("sb_event", obs, sb.pop_front());
            end
        end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (!bus0.tick);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs0();
    return 32'({bus0.pressed, bus0.is_long, bus0.short_pulse, bus0.long_pulse, bus0.repeat_pulse});
  endfunction
  function automatic logic [31:0] outs1();
    return 32'({bus1.pressed, bus1.is_long, bus1.short_pulse, bus1.long_pulse, bus1.repeat_pulse});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int k, j, e0;
    bus0.pb = '0;
    bus1.pb = '0;
    wait_clk(3);
    chk("reset_outs0", outs0(), 32'h0);
    chk("reset_outs1", outs1(), 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    wait_ticks(3);

    // short press on ch0
    wait_tick(); k = tn;
    bus0.pb[0] = 1'b1;
    sb.push_back(ev(0, K_SHORT, 0, k + 8));
    wait_ticks(1); chk("short_deb_hold", 32'(bus0.pressed), 32'h0);
    wait_ticks(1); chk("short_pressed", 32'(bus0.pressed), 32'h1);
    wait_ticks(4); bus0.pb[0] = 1'b0;
    wait_ticks(2); chk("short_release", 32'(bus0.pressed), 32'h0);
    wait_ticks(3); chk("short_drain", sb.size(), 0);

    // long hold with auto-repeat on ch1
    wait_tick(); k = tn;
    bus0.pb[1] = 1'b1;
    sb.push_back(ev(0, K_LONG, 1, k + 12));
    sb.push_back(ev(0, K_REP, 1, k + 15));
    sb.push_back(ev(0, K_REP, 1, k + 18));
    sb.push_back(ev(0, K_REP, 1, k + 21));
    wait_ticks(11); chk("long_not_yet", 32'(bus0.is_long), 32'h0);
    wait_ticks(1);  chk("long_islong", 32'(bus0.is_long), 32'h2);
    wait_ticks(8);  bus0.pb[1] = 1'b0;
    wait_ticks(1);  chk("long_still", 32'(bus0.is_long), 32'h2);
    wait_ticks(1);  chk("long_islong_fall", 32'(bus0.is_long), 32'h0);
    wait_ticks(3);  chk("long_drain", sb.size(), 0);

    // glitches on ch2: one tick wide, then 1-clk spikes between ticks
    wait_tick();
    bus0.pb[2] = 1'b1;
    wait_ticks(1); bus0.pb[2] = 1'b0;
    wait_ticks(3);
    for (int s = 0; s < 3; s++) begin
      wait_tick();
      @(negedge clk); bus0.pb[2] = 1'b1;
      @(negedge clk); bus0.pb[2] = 1'b0;
    end
    wait_ticks(4);
    chk("glitch_pressed", 32'(bus0.pressed), 32'h0);
    chk("glitch_drain", sb.size(), 0);

    // release landing on the long threshold tick
    wait_tick(); k = tn;
    bus0.pb[0] = 1'b1;
    sb.push_back(ev(0, K_SHORT, 0, k + 12));
    wait_ticks(10); bus0.pb[0] = 1'b0;
    wait_ticks(2);
    chk("tie_pressed", 32'(bus0.pressed), 32'h0);
    chk("tie_islong", 32'(bus0.is_long), 32'h0);
    wait_ticks(3); chk("tie_drain", sb.size(), 0);

    // reset while ch3 is long-held
    wait_tick(); k = tn;
    bus0.pb[3] = 1'b1;
    sb.push_back(ev(0, K_LONG, 3, k + 12));
    sb.push_back(ev(0, K_REP, 3, k + 15));
    wait_ticks(15); chk("rst_pre_islong", 32'(bus0.is_long), 32'h8);
    wait_tick(); j = tn;
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_clk(1);
      chk("rst_mid_outs", outs0(), 32'h0);
    end
    rst_n = 1'b1;
    sb.push_back(ev(0, K_LONG, 3, j + 13));
    wait_ticks(2);  chk("rst_deb_wait", 32'(bus0.pressed), 32'h0);
    wait_ticks(1);  chk("rst_repress", 32'(bus0.pressed), 32'h8);
    wait_ticks(9);  chk("rst_fresh_press", 32'(bus0.is_long), 32'h0);
    wait_ticks(1);  chk("rst_long_again", 32'(bus0.is_long), 32'h8);
    wait_ticks(1);  bus0.pb[3] = 1'b0;
    wait_ticks(2);  chk("rst_release", 32'(bus0.pressed), 32'h0);
    wait_ticks(3);  chk("rst_drain", sb.size(), 0);

    // REPEAT_TICKS=0 instance with tick held high
    wait_clk(1); e0 = cyc;
    bus1.pb[0] = 1'b1;
    sb.push_back(ev(1, K_SHORT, 1, e0 + 12));
    sb.push_back(ev(1, K_LONG, 0, e0 + 14));
    wait_clk(3); chk("norep_deb_hold", 32'(bus1.pressed), 32'h0);
    wait_clk(1); chk("norep_pressed", 32'(bus1.pressed), 32'h1);
    wait_clk(1); bus1.pb[1] = 1'b1;
    wait_clk(3); bus1.pb[1] = 1'b0;
    wait_clk(1); chk("norep_ch1_pressed", 32'(bus1.pressed), 32'h3);
    wait_clk(6); chk("norep_islong", 32'(bus1.is_long), 32'h1);
    bus1.pb[0] = 1'b0;
    wait_clk(20);
    chk("norep_release", 32'(bus1.pressed), 32'h0);
    chk("norep_islong_fall", 32'(bus1.is_long), 32'h0);
    chk("norep_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
